// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) arbiter and sequencer for the shared data-memory port.
// Optional ARB_ROUND_ROBIN_EN macro replaces fixed LSU priority with round-robin tie-breaking.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_rsp_valid,
  input  logic                    ifu_rsp_ready,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data,

  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wstrb,
  output logic                    lsu_rsp_valid,
  input  logic                    lsu_rsp_ready,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_data,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_rsp_valid,
  output logic                    mem_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  state_t                state;
  owner_t                owner;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  grant_ifu;
  logic                  grant_lsu;
  logic                  owner_rsp_ready;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t                last_grant;
`endif

  // Grants are only offered out of reset and in IDLE, so no handshake can land mid-transaction.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst && state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = (last_grant == OWN_IFU);
        grant_ifu = (last_grant == OWN_LSU);
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
`else
      grant_lsu = lsu_req_valid;
      grant_ifu = ifu_req_valid && !lsu_req_valid;
`endif
    end
  end

  assign ifu_req_ready   = grant_ifu;
  assign lsu_req_ready   = grant_lsu;
  assign ifu_rsp_data    = rsp_data;
  assign lsu_rsp_data    = rsp_data;
  assign owner_rsp_ready = (owner == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWN_IFU;
      rsp_data      <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= '0;
      mem_rsp_ready <= 1'b0;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant    <= OWN_IFU;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            owner         <= OWN_LSU;
            mem_req_addr  <= lsu_req_addr;
            mem_req_wen   <= lsu_req_wen;
            mem_req_wdata <= lsu_req_wdata;
            mem_req_wstrb <= lsu_req_wstrb;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= OWN_LSU;
`endif
          end else if (grant_ifu) begin
            owner         <= OWN_IFU;
            mem_req_addr  <= ifu_req_addr;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wstrb <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant    <= OWN_IFU;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b1;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_data      <= mem_rsp_data;
            mem_rsp_ready <= 1'b0;
            ifu_rsp_valid <= (owner == OWN_IFU);
            lsu_rsp_valid <= (owner == OWN_LSU);
            state         <= RESP;
          end
        end
        RESP: begin
          if (owner_rsp_ready) begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays both requesters and the memory,
// and a scoreboard of expected responses is checked as each response appears.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [31:0] IFU_TIE_ADDR = 32'h0000_4000;
  localparam logic [31:0] LSU_TIE_ADDR = 32'h0000_8000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ifu_req_valid = 1'b0, ifu_req_ready;
  logic [AW-1:0] ifu_req_addr = '0;
  logic          ifu_rsp_valid, ifu_rsp_ready = 1'b0;
  logic [DW-1:0] ifu_rsp_data;
  logic          lsu_req_valid = 1'b0, lsu_req_ready;
  logic [AW-1:0] lsu_req_addr = '0;
  logic          lsu_req_wen = 1'b0;
  logic [DW-1:0] lsu_req_wdata = '0;
  logic [3:0]    lsu_req_wstrb = '0;
  logic          lsu_rsp_valid, lsu_rsp_ready = 1'b0;
  logic [DW-1:0] lsu_rsp_data;
  logic          mem_req_valid, mem_req_ready = 1'b0;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_wen;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_wstrb;
  logic          mem_rsp_valid = 1'b0, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data = '0;

  typedef struct {
    bit          lsu;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valids"}, {mem_req_valid, mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid}, 4'b0000);
    check({tag, "_readies"}, {ifu_req_ready, lsu_req_ready}, 2'b00);
  endtask

  // other: 0 = lone requester, 1 = other requester raises valid after acceptance,
  //        2 = both valid at acceptance (tie).
  task automatic run_txn(input bit is_lsu, input logic [31:0] addr, input bit wen,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] rdata, input int req_stall, input int rsp_hold,
                         input bit spurious, input int other);
    exp_t e;
    exp_t got;
    if (is_lsu) begin
      lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_wen = wen;
      lsu_req_wdata = wdata; lsu_req_wstrb = wstrb;
      ifu_req_valid = (other == 2); ifu_req_addr = IFU_TIE_ADDR;
    end else begin
      ifu_req_valid = 1'b1; ifu_req_addr = addr;
      lsu_req_valid = (other == 2); lsu_req_addr = LSU_TIE_ADDR;
      lsu_req_wen = 1'b0; lsu_req_wdata = '0; lsu_req_wstrb = '0;
    end
    #1;
    check("winner_ready", is_lsu ? lsu_req_ready : ifu_req_ready, 1'b1);
    check("loser_ready", is_lsu ? ifu_req_ready : lsu_req_ready, 1'b0);
    e.lsu = is_lsu; e.chk_data = !(is_lsu && wen); e.data = rdata;
    sb.push_back(e);
    step();
    if (is_lsu) begin
      lsu_req_valid = 1'b0; ifu_req_valid = (other != 0);
    end else begin
      ifu_req_valid = 1'b0; lsu_req_valid = (other != 0);
    end

    for (int j = 0; j <= req_stall; j++) begin
      mem_req_ready = (j == req_stall);
      if (spurious && j == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = ~rdata;
      end
      check("req_valid", mem_req_valid, 1'b1);
      check("req_addr", mem_req_addr, addr);
      check("req_wen", mem_req_wen, is_lsu ? wen : 1'b0);
      check("req_wstrb", mem_req_wstrb, is_lsu ? wstrb : 4'h0);
      if (is_lsu && wen) check("req_wdata", mem_req_wdata, wdata);
      check("req_rsp_ready", mem_rsp_ready, 1'b0);
      check("req_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
      check("req_no_accept", {ifu_req_ready, lsu_req_ready}, 2'b00);
      step();
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b0;

    check("wait_req_valid", mem_req_valid, 1'b0);
    check("wait_rsp_ready", mem_rsp_ready, 1'b1);
    check("wait_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
    mem_rsp_valid = 1'b1; mem_rsp_data = rdata;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_data = rdata ^ 32'h5A5A_5A5A;

    check("sb_nonempty", sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      got = sb.pop_front();
      for (int h = 0; h <= rsp_hold; h++) begin
        if (got.lsu) begin
          lsu_rsp_ready = (h == rsp_hold); ifu_rsp_ready = 1'b1;
        end else begin
          ifu_rsp_ready = (h == rsp_hold); lsu_rsp_ready = 1'b1;
        end
        check("rsp_owner", {lsu_rsp_valid, ifu_rsp_valid}, got.lsu ? 2'b10 : 2'b01);
        if (got.chk_data)
          check("rsp_data", got.lsu ? lsu_rsp_data : ifu_rsp_data, got.data);
        check("rsp_no_accept", {ifu_req_ready, lsu_req_ready}, 2'b00);
        check("rsp_mem_quiet", {mem_req_valid, mem_rsp_ready}, 2'b00);
        step();
      end
    end
    ifu_rsp_ready = 1'b0; lsu_rsp_ready = 1'b0;
    check("post_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 2'b00);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    step();
    step();
    check_idle_outputs("reset");
    check("reset_data", {ifu_rsp_data, mem_req_addr}, 64'h0);
    check("reset_req_fields", {mem_req_wen, mem_req_wstrb, mem_req_wdata}, 37'h0);
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_dut();

    // Single IFU read, zero wait states: response exactly 3 cycles after acceptance.
    run_txn(1'b0, 32'h8000_0000, 1'b0, '0, '0, 32'hDEAD_BEEF, 0, 0, 1'b0, 0);

    // LSU store held through two stalled cycles, then one response.
    run_txn(1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 4'h3, 32'h0, 2, 0, 1'b0, 0);

    // Owner stalls the response for 5 cycles while the IFU is waiting to be served.
    run_txn(1'b1, 32'h0000_0200, 1'b0, '0, '0, 32'hCAFE_F00D, 0, 5, 1'b0, 1);
    ifu_req_valid = 1'b0;

    // Spurious memory response during REQ must be ignored.
    run_txn(1'b0, 32'h0000_0300, 1'b0, '0, '0, 32'h0BAD_C0DE, 1, 0, 1'b1, 0);

    // Reset while in WAIT aborts the transaction; a late response produces nothing.
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h0000_0040; mem_req_ready = 1'b1;
    step();
    ifu_req_valid = 1'b0;
    step();
    mem_req_ready = 1'b0;
    check("abort_in_wait", mem_rsp_ready, 1'b1);
    rst = 1'b0;
    step();
    check_idle_outputs("abort_reset");
    rst = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777_7777;
    for (int k = 0; k < 2; k++) begin
      step();
      check_idle_outputs("late_rsp");
    end
    mem_rsp_valid = 1'b0;
    run_txn(1'b1, 32'h0000_0500, 1'b0, '0, '0, 32'h1357_9BDF, 0, 0, 1'b0, 0);

    // Simultaneous requests, four transactions from a fresh reset.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      bit win_lsu = (i % 2 == 0);
`else
      bit win_lsu = 1'b1;
`endif
      run_txn(win_lsu, win_lsu ? LSU_TIE_ADDR : IFU_TIE_ADDR, 1'b0, '0, '0,
              32'h1000_0000 + 32'(i), 0, 0, 1'b0, 2);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    step();

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer that shares the single data-memory port between the instruction-fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between the front-end/mem-stage pipeline logic and the memory model/bus. It accepts at most one transaction at a time, forwards it to memory and returns the response to the requester that issued it. Responses always come back in order because only one transaction is ever outstanding.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-low reset
- ifu_req_valid / ifu_req_ready  in/out  1  IFU request handshake
- ifu_req_addr  in  ADDR_WIDTH  IFU read address
- ifu_rsp_valid / ifu_rsp_ready  out/in  1  IFU response handshake
- ifu_rsp_data  out  DATA_WIDTH  IFU read data
- lsu_req_valid / lsu_req_ready  in/out  1  LSU request handshake
- lsu_req_addr  in  ADDR_WIDTH  LSU address
- lsu_req_wen  in  1  1 = store, 0 = load
- lsu_req_wdata  in  DATA_WIDTH  store data
- lsu_req_wstrb  in  DATA_WIDTH/8  store byte strobes
- lsu_rsp_valid / lsu_rsp_ready  out/in  1  LSU response handshake
- lsu_rsp_data  out  DATA_WIDTH  load data (don't-care for stores)
- mem_req_valid / mem_req_ready  out/in  1  memory request handshake
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb  out  as LSU  request fields
- mem_rsp_valid / mem_rsp_ready  in/out  1  memory response handshake
- mem_rsp_data  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. An owner register records the requester (IFU/LSU) that holds the grant.
- IDLE: the arbiter selects at most one valid requester and asserts that requester's req_ready combinationally. On the handshake it latches addr, wen, wdata and wstrb, sets the owner and moves to REQ. IFU requests are latched with wen=0 and wstrb=0.
- REQ: mem_req_valid=1, driven from the latched registers. When mem_req_ready=1 the FSM moves to WAIT.
- WAIT: mem_rsp_ready=1. When mem_rsp_valid=1 the arbiter latches mem_rsp_data and moves to RESP.
- RESP: the owner's rsp_valid=1, with rsp_data taken from the latch. On the owner's rsp_ready the FSM returns to IDLE.
- req_ready is 0 for both requesters in every state except IDLE. A requester must hold valid and its fields stable until accepted.
- Priority without the macro: the LSU always wins a simultaneous request, so the older in-flight instruction is served first.
- The non-owner's rsp_valid is always 0. Stores also produce exactly one response.

## Timing
- Reset values: all *_ready and *_valid outputs are 0, the FSM is in IDLE, the owner is IFU, and data/addr outputs are 0. Reset in any state aborts the pending transaction with no response, and the arbiter is back in IDLE on the next cycle.
- Best-case latency is 3 cycles: request accepted at cycle 0, mem_req_valid at cycle 1, mem_rsp captured at cycle 2, rsp_valid at cycle 3. A memory response is never accepted in the same cycle as the request.
- Back-to-back: the earliest next acceptance is in the cycle after the RESP handshake (IDLE cycle).
- Outputs in REQ and RESP are held stable while the corresponding ready is low.
- If mem_rsp_valid arrives while in REQ it is ignored (mem_rsp_ready=0).

## Configuration
- ARB_ROUND_ROBIN_EN defined: a last_grant register (reset value IFU) is updated at every IDLE acceptance.
  - On a simultaneous request, the requester that was not last granted wins.
  - A lone requester always wins.
  - The first tie after reset therefore goes to the LSU.
- ARB_ROUND_ROBIN_EN undefined: fixed LSU priority and no last_grant register.

## Test plan
- Single IFU read of 0x8000_0000, memory returns 0xDEAD_BEEF with zero wait states -> ifu_rsp_valid exactly at cycle 3 with data 0xDEAD_BEEF; lsu_rsp_valid stays 0.
- LSU store to 0x100, wdata 0x1234_5678, wstrb 0x3, memory applies 2 cycles of mem_req_ready=0 -> mem_req fields held stable for 3 cycles, then one lsu_rsp_valid pulse.
- IFU and LSU request in the same cycle, repeated for 4 transactions -> without the macro the LSU is granted all 4 and the IFU is starved while the LSU keeps requesting; with ARB_ROUND_ROBIN_EN the grants are LSU, IFU, LSU, IFU.
- Owner holds rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_data stay stable, and no new request is accepted (both req_ready=0).
- rst=0 asserted while in WAIT -> next cycle all valids/readies are 0 and the FSM is in IDLE; a late mem_rsp_valid produces no response.
- Spurious mem_rsp_valid during REQ -> ignored; the real response in WAIT is delivered once.
